// File: rtl/vram_prefetch.sv
// SDRAM video prefetcher: fetches one word per clkref cycle into a small FWFT FIFO.
// Optional underrun statistics are built when VRAM_PREFETCH_STATS_EN is defined.
module vram_prefetch #(
  parameter int DEPTH    = 8,
  parameter int DATA_LAT = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clkref,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [22:0]              i_base_addr,
  input  logic                     i_cpu_claim,
  output logic [22:0]              o_vram_addr,
  input  logic [15:0]              i_vram_dout,
  input  logic                     i_rd_en,
  output logic [15:0]              o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic [15:0]              o_underrun_cnt,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SYNC = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_clkref_d;
  logic [22:0]     r_ptr;
  logic [22:0]     r_vram_addr;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;

  logic            w_ref_edge;
  logic            w_set_addr;
  logic            w_clr_cnt;
  logic            w_capture;
  logic            w_push;
  logic            w_pop;
  logic [22:0]     w_base_word;

  assign w_ref_edge  = i_clkref & ~r_clkref_d;
  assign w_base_word = i_base_addr & ~23'd1;

  // start outranks stop; both override whatever the fetch sequence was doing
  always_comb begin
    w_next     = r_state;
    w_set_addr = 1'b0;
    w_clr_cnt  = 1'b0;
    w_capture  = 1'b0;
    if (i_start) begin
      w_next = S_ARM;
    end else if (i_stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_IDLE;
        S_ARM: begin
          if (r_level != FULL_LVL) begin
            w_set_addr = 1'b1;
            w_next     = S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_ref_edge && !i_cpu_claim) begin
            w_clr_cnt = 1'b1;
            w_next    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            w_capture = 1'b1;
            w_next    = S_ARM;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_clkref_d  <= 1'b0;
      r_ptr       <= '0;
      r_vram_addr <= '0;
      r_cnt       <= '0;
    end else begin
      r_state    <= w_next;
      r_clkref_d <= i_clkref;
      if (i_start)
        r_ptr <= w_base_word;
      else if (w_capture)
        r_ptr <= r_ptr + 23'd2;
      // address only moves in ARM, so it is stable across the whole fetch
      if (w_set_addr)
        r_vram_addr <= r_ptr;
      if (w_clr_cnt)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Read side: a pop happens on any cycle with rd_en=1 and empty=0 (start cycles excepted);
  // rd_data shows the head word while empty=0 and advances in the pop cycle.
  assign w_push = w_capture;
  assign w_pop  = i_rd_en && (r_level != '0) && !i_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_vram_dout;
  end

`ifdef VRAM_PREFETCH_STATS_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_underrun_cnt <= '0;
    else if (i_start)
      r_underrun_cnt <= '0;
    else if (i_rd_en && (r_level == '0) && (r_underrun_cnt != 16'hFFFF))
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign o_underrun_cnt = r_underrun_cnt;
`else
  assign o_underrun_cnt = 16'd0;
`endif

  assign o_vram_addr = r_vram_addr;
  assign o_rd_data   = (r_level == '0) ? 16'd0 : r_mem[r_rd_ptr];
  assign o_empty     = (r_level == '0);
  assign o_full      = (r_level == FULL_LVL);
  assign o_level     = r_level;
  assign o_busy      = (r_state != S_IDLE);
  assign o_state     = r_state;

endmodule
